// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding and PC constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StHold   = 2'd2,
    StHalted = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/pc_range_check.sv
// Maps a byte PC onto a program-memory word index and flags PCs that cannot be fetched.
module pc_range_check
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] PC_RESET     = DATA_WIDTH'(PC_RESET_DEFAULT)
) (
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic [DATA_WIDTH-1:0] word_idx_o,
  output logic                  fault_o
);

  localparam logic [DATA_WIDTH-1:0] Depth = DATA_WIDTH'(MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] offset;

  always_comb begin
    offset     = pc_i - PC_RESET;
    word_idx_o = offset >> 2;
    // Below-base PCs wrap to a huge index, but are flagged explicitly for clarity.
    fault_o    = (pc_i[1:0] != 2'b00) || (pc_i < PC_RESET) || (word_idx_o >= Depth);
  end

endmodule

// File: rtl/fetch_controller.sv
// Program counter, memory sequencing and one-entry instruction buffer with valid/ready output.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] PC_RESET     = DATA_WIDTH'(PC_RESET_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  mem_enable_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  input  logic [DATA_WIDTH-1:0] mem_instruction_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  fault_o,
  output logic [DATA_WIDTH-1:0] fetch_count_o
);

  localparam logic [DATA_WIDTH-1:0] Step = DATA_WIDTH'(PC_STEP);
  localparam logic [DATA_WIDTH-1:0] One  = DATA_WIDTH'(1);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;

  logic [DATA_WIDTH-1:0] word_idx;
  logic                  range_fault;
  logic                  accept;
  logic                  fetch_attempt;

  pc_range_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .PC_RESET    (PC_RESET)
  ) u_pc_range_check (
    .pc_i      (pc_q),
    .word_idx_o(word_idx),
    .fault_o   (range_fault)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pc_plus4_d    = pc_plus4_q;
    fault_d       = fault_q;
    count_d       = count_q;
    accept        = valid_q && instr_ready_i;
    // HOLD always has a full buffer, so both active states fetch when it frees up.
    fetch_attempt = (!valid_q || instr_ready_i);

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch, StHold: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          valid_d = 1'b0;
          state_d = StFetch;
        end else begin
          if (accept) begin
            valid_d = 1'b0;
            count_d = count_q + One;
          end
          if (halt_i) begin
            state_d = StHalted;
          end else if (fetch_attempt && range_fault) begin
            fault_d = 1'b1;
            state_d = StHalted;
          end else if (fetch_attempt) begin
            instr_d    = mem_instruction_i;
            instr_pc_d = pc_q;
            pc_plus4_d = pc_q + Step;
            valid_d    = 1'b1;
            pc_d       = pc_q + Step;
            state_d    = StFetch;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHalted: begin
        if (accept) begin
          valid_d = 1'b0;
          count_d = count_q + One;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= PC_RESET;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      pc_plus4_q <= Step;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pc_plus4_q <= pc_plus4_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  // Memory strobe is suppressed in HOLD and for any PC that would fault.
  assign mem_enable_o  = (state_q == StFetch) && !range_fault;
  assign mem_address_o = word_idx;

  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign pc_plus4_o    = pc_plus4_q;
  assign fault_o       = fault_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_controller;

  localparam logic [31:0] PCR = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_ready_i = 1'b0;
  logic        mem_enable_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_instruction_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] pc_plus4_o;
  logic        fault_o;
  logic [31:0] fetch_count_o;

  logic [31:0] rom [64];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit          m_started, m_halted, m_stalled, m_valid, m_fault;
  logic [31:0] m_pc, m_instr, m_ipc, m_p4, m_count;

  fetch_controller #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(64),
    .PC_RESET    (PCR)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .halt_i           (halt_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .mem_enable_o     (mem_enable_o),
    .mem_address_o    (mem_address_o),
    .mem_instruction_i(mem_instruction_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .pc_plus4_o       (pc_plus4_o),
    .fault_o          (fault_o),
    .fetch_count_o    (fetch_count_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_instruction_i = 32'hDEAD_BEEF;
    if (mem_address_o < 32'd64) mem_instruction_i = rom[mem_address_o[5:0]];
  end

  function automatic bit pc_bad(logic [31:0] pc);
    return (pc % 4 != 0) || (pc < PCR) || (pc >= PCR + 32'd256);
  endfunction

  function automatic logic [31:0] rom_at(logic [31:0] pc);
    logic [31:0] idx;
    idx = (pc - PCR) / 4;
    return rom[idx[5:0]];
  endfunction

  function automatic void model_reset();
    m_started = 0; m_halted = 0; m_stalled = 0; m_valid = 0; m_fault = 0;
    m_pc = PCR; m_instr = 0; m_ipc = 0; m_p4 = 4; m_count = 0;
  endfunction

  // One clock edge of the fetch rules, using the inputs as they stand before the edge.
  function automatic void model_step();
    bit had_valid;
    had_valid = m_valid;
    if (!m_started) begin
      if (start_i) m_started = 1;
      return;
    end
    if (m_halted) begin
      if (m_valid && instr_ready_i) begin m_valid = 0; m_count++; end
      return;
    end
    if (redirect_i) begin
      m_pc = redirect_pc_i; m_valid = 0; m_stalled = 0;
      return;
    end
    if (had_valid && instr_ready_i) begin m_valid = 0; m_count++; end
    if (halt_i) begin
      m_halted = 1;
    end else if (!had_valid || instr_ready_i) begin
      if (pc_bad(m_pc)) begin
        m_fault = 1; m_halted = 1;
      end else begin
        m_instr = rom_at(m_pc); m_ipc = m_pc; m_p4 = m_pc + 4;
        m_valid = 1; m_pc = m_pc + 4; m_stalled = 0;
      end
    end else begin
      m_stalled = 1;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    start_i = 0; halt_i = 0; redirect_i = 0; instr_ready_i = 0; redirect_pc_i = '0;
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic begin_run();
    apply_reset();
    start_i = 1; instr_ready_i = 1;
    tick();
    start_i = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({instr_valid_o, instr_o, instr_pc_o, pc_plus4_o} !== {1'b0, 32'h0, 32'h0, 32'h4})
      $display("FAIL reset_buffer got v=%b i=%h pc=%h p4=%h want 0/0/0/4",
               instr_valid_o, instr_o, instr_pc_o, pc_plus4_o);
    else n_pass++;
    n_checks++;
    if ({fault_o, fetch_count_o, mem_enable_o, mem_address_o} !== {1'b0, 32'h0, 1'b0, 32'h0})
      $display("FAIL reset_status got f=%b cnt=%0d en=%b addr=%h want 0/0/0/0",
               fault_o, fetch_count_o, mem_enable_o, mem_address_o);
    else n_pass++;
    start_i = 1; instr_ready_i = 1;
    tick();
    start_i = 0;
    n_checks++;
    if (mem_enable_o !== 1'b1 || instr_valid_o !== 1'b0)
      $display("FAIL start_fetch got en=%b v=%b want 1/0", mem_enable_o, instr_valid_o);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (instr_valid_o !== 1'b1) $display("FAIL pre_reset_valid got %b want 1", instr_valid_o);
    else n_pass++;
    #2 reset = 1;
    model_reset();
    #1;
    n_checks++;
    if ({instr_valid_o, pc_plus4_o, fetch_count_o, mem_enable_o, instr_pc_o} !==
        {1'b0, 32'h4, 32'h0, 1'b0, 32'h0})
      $display("FAIL async_reset got v=%b p4=%h cnt=%0d en=%b pc=%h want 0/4/0/0/0",
               instr_valid_o, pc_plus4_o, fetch_count_o, mem_enable_o, instr_pc_o);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 0;
    start_i = 1;
    tick();
    start_i = 0;
    tick();
    n_checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== PCR || instr_o !== rom[0])
      $display("FAIL first_fetch got v=%b pc=%h i=%h want 1/%h/%h",
               instr_valid_o, instr_pc_o, instr_o, PCR, rom[0]);
    else n_pass++;
  endtask

  task automatic test_streaming();
    begin_run();
    for (int i = 0; i < 11; i++) begin
      tick();
      n_checks++;
      if (instr_valid_o !== 1'b1 || instr_pc_o !== PCR + 4 * i || instr_o !== rom[i]
          || pc_plus4_o !== PCR + 4 * i + 4)
        $display("FAIL stream_%0d got v=%b pc=%h i=%h p4=%h want 1/%h/%h/%h", i,
                 instr_valid_o, instr_pc_o, instr_o, pc_plus4_o, PCR + 4 * i, rom[i],
                 PCR + 4 * i + 4);
      else n_pass++;
    end
    n_checks++;
    if (fetch_count_o !== 32'd10) $display("FAIL stream_count got %0d want 10", fetch_count_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    begin_run();
    tick(); tick();
    instr_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (instr_valid_o !== 1'b1 || instr_pc_o !== PCR + 4 || instr_o !== rom[1]
          || mem_enable_o !== 1'b0)
        $display("FAIL stall_%0d got v=%b pc=%h i=%h en=%b want 1/%h/%h/0", i,
                 instr_valid_o, instr_pc_o, instr_o, mem_enable_o, PCR + 4, rom[1]);
      else n_pass++;
    end
    instr_ready_i = 1;
    tick();
    n_checks++;
    if (instr_pc_o !== PCR + 8 || instr_o !== rom[2] || fetch_count_o !== 32'd2)
      $display("FAIL resume got pc=%h i=%h cnt=%0d want %h/%h/2",
               instr_pc_o, instr_o, fetch_count_o, PCR + 8, rom[2]);
    else n_pass++;
    tick();
    n_checks++;
    if (instr_pc_o !== PCR + 12) $display("FAIL resume_next got %h want %h", instr_pc_o, PCR + 12);
    else n_pass++;
  endtask

  task automatic test_redirect();
    begin_run();
    tick(); tick();
    redirect_i = 1; redirect_pc_i = PCR + 32'h20;
    tick();
    redirect_i = 0;
    n_checks++;
    if (instr_valid_o !== 1'b0 || fetch_count_o !== 32'd1)
      $display("FAIL redirect_bubble got v=%b cnt=%0d want 0/1", instr_valid_o, fetch_count_o);
    else n_pass++;
    tick();
    n_checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== PCR + 32'h20 || instr_o !== rom[8]
        || fetch_count_o !== 32'd1)
      $display("FAIL redirect_target got v=%b pc=%h i=%h cnt=%0d want 1/%h/%h/1",
               instr_valid_o, instr_pc_o, instr_o, fetch_count_o, PCR + 32'h20, rom[8]);
    else n_pass++;
  endtask

  task automatic test_fault();
    begin_run();
    tick();
    redirect_i = 1; redirect_pc_i = PCR + 32'h100;
    tick();
    redirect_i = 0;
    n_checks++;
    if (mem_enable_o !== 1'b0 || fault_o !== 1'b0)
      $display("FAIL fault_pending got en=%b f=%b want 0/0", mem_enable_o, fault_o);
    else n_pass++;
    tick();
    n_checks++;
    if (fault_o !== 1'b1 || instr_valid_o !== 1'b0 || mem_enable_o !== 1'b0)
      $display("FAIL fault_range got f=%b v=%b en=%b want 1/0/0",
               fault_o, instr_valid_o, mem_enable_o);
    else n_pass++;
    start_i = 1; redirect_i = 1; redirect_pc_i = PCR;
    tick(); tick();
    start_i = 0; redirect_i = 0;
    n_checks++;
    if (fault_o !== 1'b1 || instr_valid_o !== 1'b0 || mem_enable_o !== 1'b0)
      $display("FAIL halted_sticky got f=%b v=%b en=%b want 1/0/0",
               fault_o, instr_valid_o, mem_enable_o);
    else n_pass++;
    begin_run();
    redirect_i = 1; redirect_pc_i = PCR + 32'h2;
    tick();
    redirect_i = 0;
    tick();
    n_checks++;
    if (fault_o !== 1'b1 || instr_valid_o !== 1'b0)
      $display("FAIL fault_misalign got f=%b v=%b want 1/0", fault_o, instr_valid_o);
    else n_pass++;
  endtask

  task automatic test_halt_pending();
    begin_run();
    tick();
    instr_ready_i = 0; halt_i = 1;
    tick(); tick();
    n_checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== PCR || fetch_count_o !== 32'd0
        || mem_enable_o !== 1'b0)
      $display("FAIL halt_hold got v=%b pc=%h cnt=%0d en=%b want 1/%h/0/0",
               instr_valid_o, instr_pc_o, fetch_count_o, mem_enable_o, PCR);
    else n_pass++;
    instr_ready_i = 1;
    tick();
    n_checks++;
    if (instr_valid_o !== 1'b0 || fetch_count_o !== 32'd1)
      $display("FAIL halt_drain got v=%b cnt=%0d want 0/1", instr_valid_o, fetch_count_o);
    else n_pass++;
    tick();
    n_checks++;
    if (instr_valid_o !== 1'b0 || fetch_count_o !== 32'd1 || mem_enable_o !== 1'b0)
      $display("FAIL halt_quiet got v=%b cnt=%0d en=%b want 0/1/0",
               instr_valid_o, fetch_count_o, mem_enable_o);
    else n_pass++;
    halt_i = 0;
  endtask

  task automatic test_random();
    logic [31:0] exp_en_addr, got_en_addr;
    bit          exp_en;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0 || (m_halted && !m_valid && $urandom_range(0, 7) == 0))
        apply_reset();
      start_i       = ($urandom_range(0, 7) == 0);
      halt_i        = ($urandom_range(0, 119) == 0);
      redirect_i    = ($urandom_range(0, 11) == 0);
      instr_ready_i = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       redirect_pc_i = PCR + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
        1:       redirect_pc_i = PCR + 32'd256 + 4 * $urandom_range(0, 15);
        2:       redirect_pc_i = PCR - 4 * $urandom_range(1, 8);
        3, 4:    redirect_pc_i = PCR + 4 * $urandom_range(58, 63);
        default: redirect_pc_i = PCR + 4 * $urandom_range(0, 63);
      endcase
      tick();
      exp_en      = m_started && !m_halted && !m_stalled && !pc_bad(m_pc);
      exp_en_addr = (m_pc - PCR) >> 2;
      got_en_addr = mem_address_o;
      n_checks++;
      if ({mem_enable_o, got_en_addr, instr_valid_o, instr_o, instr_pc_o, pc_plus4_o, fault_o,
           fetch_count_o} !==
          {exp_en, exp_en_addr, m_valid, m_instr, m_ipc, m_p4, m_fault, m_count})
        $display("FAIL random_%0d got en=%b a=%h v=%b i=%h pc=%h p4=%h f=%b c=%0d want en=%b a=%h v=%b i=%h pc=%h p4=%h f=%b c=%0d",
                 cyc, mem_enable_o, got_en_addr, instr_valid_o, instr_o, instr_pc_o, pc_plus4_o,
                 fault_o, fetch_count_o, exp_en, exp_en_addr, m_valid, m_instr, m_ipc, m_p4,
                 m_fault, m_count);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    model_reset();
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_fault();
    test_halt_pending();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the combinational program memory for the single-cycle/pipelined datapath. Owns the program counter, drives the memory's enable and word address, and registers each fetched instruction into a one-entry output buffer. The buffer is handed to decode through a valid/ready handshake. Also handles start, branch/jump redirect, halt and out-of-range fault, and keeps a count of accepted instructions.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction, PC and address width
- MEMORY_DEPTH, 64, program memory depth in words
- PC_RESET, 32'h0040_0000, byte address of the first instruction; also the base mapped to word 0

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- start_i  input  1  one-cycle pulse; leaves IDLE
- halt_i  input  1  level; stops fetching at the next edge
- redirect_i  input  1  branch/jump taken, one cycle
- redirect_pc_i  input  DATA_WIDTH  byte target address
- mem_enable_o  output  1  to memory Enable_i
- mem_address_o  output  DATA_WIDTH  word index, (pc − PC_RESET) >> 2
- mem_instruction_i  input  DATA_WIDTH  from memory Instruction_o, same cycle
- instr_valid_o  output  1  output buffer holds an instruction
- instr_ready_i  input  1  decode accepts
- instr_o  output  DATA_WIDTH  buffered instruction
- instr_pc_o  output  DATA_WIDTH  byte PC of instr_o
- pc_plus4_o  output  DATA_WIDTH  instr_pc_o + 4
- fault_o  output  1  sticky; out-of-range or misaligned PC
- fetch_count_o  output  DATA_WIDTH  number of accepted instructions

## Operation
- **States:** IDLE, FETCH, HOLD, HALTED.
- **Reset (asynchronous, any state):**
  - State returns to IDLE and pc returns to PC_RESET.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0, pc_plus4_o=4.
  - fault_o=0, fetch_count_o=0, mem_enable_o=0, mem_address_o=0.
- **IDLE:** mem_enable_o=0. start_i moves to FETCH.
- **FETCH:** mem_enable_o=1 and mem_address_o derives from pc. Each edge with buffer free or consumed, the controller:
  - loads instr_o ← mem_instruction_i;
  - loads instr_pc_o ← pc and pc_plus4_o ← pc+4;
  - sets instr_valid_o=1;
  - updates pc ← pc+4.
- **Buffer free or consumed:** (!instr_valid_o) or (instr_valid_o && instr_ready_i).
- **FETCH → HOLD:** when instr_valid_o=1 and instr_ready_i=0, the state moves to HOLD.
- **HOLD:**
  - mem_enable_o=0; pc and the buffer are frozen.
  - When instr_ready_i=1, the buffered instruction is accepted and a new fetch completes the same edge. The state returns to FETCH.
- **Accept:** instr_valid_o && instr_ready_i at an edge. fetch_count_o increments, wrapping modulo 2^DATA_WIDTH.
- **Redirect (FETCH or HOLD):**
  - Takes priority over fetch and accept.
  - pc ← redirect_pc_i and instr_valid_o ← 0. The buffered instruction is discarded and not counted.
  - The state goes to FETCH.
  - Ignored in IDLE and HALTED.
- **Fault:** checked whenever a fetch would be issued, i.e. the current pc.
  - Conditions: pc[1:0] ≠ 0, pc < PC_RESET, or word index ≥ MEMORY_DEPTH.
  - Response: fault_o ← 1, state goes to HALTED, no load into the buffer, mem_enable_o=0 that cycle.
  - A misaligned redirect_pc_i is loaded, then faults on its first fetch attempt.
- **halt_i in FETCH/HOLD:** moves to HALTED at the next edge. An accept on that edge still completes; no new fetch occurs.
- **HALTED:**
  - mem_enable_o=0.
  - instr_valid_o stays until accepted, then drops.
  - Only reset exits.
- **Simultaneous events:**
  - reset dominates everything.
  - Priority after reset: redirect > halt > fault > fetch.
  - start_i outside IDLE is ignored.

## Timing
- Memory is combinational: the address is driven from the pc register and the instruction is captured at the same edge.
- Fetch-to-valid latency is 1 cycle. First instr_valid_o comes 1 cycle after the start_i edge.
- Throughput is one instruction per cycle while instr_ready_i=1.
- After a redirect, instr_valid_o is low for exactly one cycle. The target instruction is valid the following cycle.
- All outputs are registered, except mem_enable_o and mem_address_o, which decode from state/pc only. Neither depends combinationally on instr_ready_i.

## Structure
- Shared package `fetch_pkg`:
  - state encoding (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, HALTED=2'd3);
  - PC_RESET default;
  - PC_STEP=4.
- One sub-module, `pc_range_check`: combinational. Takes pc, PC_RESET and MEMORY_DEPTH, and produces word index and fault.
- The FSM, buffer and counter stay in `fetch_controller`.

## Test plan
- **Reset/start:** assert reset mid-FETCH with valid=1. All outputs return to reset values immediately. start_i then gives instr_pc_o=0x00400000 one cycle later, with instr_o=rom[0].
- **Streaming:** ready held at 1 for 10 cycles. instr_pc_o runs 0x00400000…0x00400024 back-to-back and fetch_count_o=10.
- **Backpressure:** drop ready for 3 cycles after the second instruction. instr_o and instr_pc_o hold 0x00400004 and mem_enable_o=0. Resume gives 0x00400008 the next cycle with no skipped or duplicated PC.
- **Redirect:** redirect_i with target 0x00400020 while a buffer is valid and ready=1. Valid is low one cycle, then instr_pc_o=0x00400020 and instr_o=rom[8]. The discarded instruction is not counted.
- **Fault:** redirect to 0x00400100 (word 64) gives fault_o=1, state HALTED, mem_enable_o=0, no further valid. Redirect to 0x00400002 gives fault_o=1.
- **Halt with pending:** assert halt_i while valid=1 and ready=0. The state becomes HALTED and valid holds. After ready=1, valid drops, fetch_count_o increments by 1, and no new fetch occurs.
